// File: rtl/mips_mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM states, opcode/funct values, ALU control codes and datapath mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        RTYPEEX,
        RTYPEWB,
        BRANCHEX,
        ADDIEX,
        ADDIWB,
        JEX,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that hold a memory request open and therefore run the wait counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Memory handshake between the controller (master) and the shared
// instruction/data memory (slave).
interface mips_mc_controller_if;
    logic mem_req;
    logic memwrite;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output memwrite, output iord, input mem_ready);
    modport slave  (input mem_req, input memwrite, input iord, output mem_ready);
endinterface

// File: rtl/mips_mc_controller_aludec.sv
// ALU decoder: maps aluop (and funct for R-type) to an ALU control code and
// flags funct values the core does not implement.
module mips_mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic [5:0]           funct,
    input  aluop_t               aluop,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_funct
);

    logic [2:0] fcode;

    // The illegal flag depends on funct alone so DECODE can test it before RTYPEEX.
    always_comb begin
        fcode         = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  fcode = ALU_ADD;
            FN_SUB:  fcode = ALU_SUB;
            FN_AND:  fcode = ALU_AND;
            FN_OR:   fcode = ALU_OR;
            FN_SLT:  fcode = ALU_SLT;
            default: illegal_funct = 1'b1;
        endcase
    end

    always_comb begin
        alucontrol = ALUCTRL_W'(ALU_ADD);
        case (aluop)
            ALUOP_ADD:   alucontrol = ALUCTRL_W'(ALU_ADD);
            ALUOP_SUB:   alucontrol = ALUCTRL_W'(ALU_SUB);
            ALUOP_FUNCT: alucontrol = ALUCTRL_W'(fcode);
            default:     alucontrol = ALUCTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction over a
// shared memory, with handshake timeout, sticky error flags and a retire counter.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int MAX_WAIT   = 15,
    parameter int ENABLE_BNE = 1,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    mips_mc_controller_if.master mem,
    output logic                 irwrite,
    output logic                 pcen,
    output logic                 regwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 halted,
    output logic                 err_illegal,
    output logic                 err_bus,
    output logic [CNT_W-1:0]     retired
);

    state_t     state, state_n;
    aluop_t     aluop;
    logic [7:0] waitcnt;
    logic       funct_bad, timeout, retire;
    logic       set_illegal, set_bus;
    logic       irwrite_c, pcen_c, regwrite_c, memwrite_c;

    mips_mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .funct         (funct),
        .aluop         (aluop),
        .alucontrol    (alucontrol),
        .illegal_funct (funct_bad)
    );

    assign timeout = (waitcnt == 8'(MAX_WAIT)) && !mem.mem_ready;
    assign retire  = (state_n == FETCH) &&
                     (state inside {MEMWB, MEMWR, RTYPEWB, BRANCHEX, ADDIWB, JEX});
    assign halted  = (state == ERROR);

    // Write enables are held low while reset is asserted, even though FETCH is live.
    assign irwrite      = irwrite_c  & ~reset;
    assign pcen         = pcen_c     & ~reset;
    assign regwrite     = regwrite_c & ~reset;
    assign mem.memwrite = memwrite_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitcnt     <= '0;
            retired     <= '0;
            err_illegal <= 1'b0;
            err_bus     <= 1'b0;
        end else begin
            if (state_n != state)
                waitcnt <= '0;
            else if (is_wait_state(state) && !mem.mem_ready)
                waitcnt <= waitcnt + 8'd1;
            if (retire)      retired     <= retired + CNT_W'(1);
            if (set_illegal) err_illegal <= 1'b1;
            if (set_bus)     err_bus     <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        mem.mem_req = 1'b0;
        mem.iord    = 1'b0;
        memwrite_c  = 1'b0;
        irwrite_c   = 1'b0;
        pcen_c      = 1'b0;
        regwrite_c  = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        pcsrc       = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        set_illegal = 1'b0;
        set_bus     = 1'b0;
        case (state)
            FETCH: begin
                mem.mem_req = 1'b1;
                alusrcb     = SRCB_FOUR;
                if (mem.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcen_c    = 1'b1;
                    state_n   = DECODE;
                end else if (timeout) begin
                    set_bus = 1'b1;
                    state_n = ERROR;
                end
            end
            DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE: begin
                        state_n     = funct_bad ? ERROR : RTYPEEX;
                        set_illegal = funct_bad;
                    end
                    OP_BEQ:  state_n = BRANCHEX;
                    OP_BNE: begin
                        state_n     = (ENABLE_BNE != 0) ? BRANCHEX : ERROR;
                        set_illegal = (ENABLE_BNE == 0);
                    end
                    OP_ADDI: state_n = ADDIEX;
                    OP_J:    state_n = JEX;
                    default: begin
                        state_n     = ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_n = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                if (mem.mem_ready) begin
                    state_n = MEMWB;
                end else if (timeout) begin
                    set_bus = 1'b1;
                    state_n = ERROR;
                end
            end
            MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 1'b1;
                state_n    = FETCH;
            end
            MEMWR: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                memwrite_c  = 1'b1;
                if (mem.mem_ready) begin
                    state_n = FETCH;
                end else if (timeout) begin
                    set_bus = 1'b1;
                    state_n = ERROR;
                end
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_n = RTYPEWB;
            end
            RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst     = 1'b1;
                state_n    = FETCH;
            end
            BRANCHEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                pcen_c  = (op == OP_BNE) ? ~zero : zero;
                state_n = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_n = ADDIWB;
            end
            ADDIWB: begin
                regwrite_c = 1'b1;
                state_n    = FETCH;
            end
            JEX: begin
                pcsrc   = PCSRC_JUMP;
                pcen_c  = 1'b1;
                state_n = FETCH;
            end
            ERROR:   state_n = ERROR;
            default: state_n = ERROR;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: scripted instruction sequences push
// expected per-cycle control words, a negedge monitor pops and compares them.
module tb_mips_mc_controller;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    typedef enum int {
        B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR, B_RTYPEEX,
        B_RTYPEWB, B_BRANCHEX, B_ADDIEX, B_ADDIWB, B_JEX, B_ERROR
    } bst_t;

    typedef struct {
        int          sel;
        string       tag;
        logic [18:0] ctrl;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0, reset1, zero0, zero1;
    logic [5:0] op0, funct0, op1, funct1;

    mips_mc_controller_if if0 ();
    mips_mc_controller_if if1 ();

    wire        irw0, pcen0, rw0, rd0, mtr0, asa0, hlt0, ei0, eb0;
    wire [1:0]  asb0, pcs0;
    wire [2:0]  alu0;
    wire [31:0] ret0;
    wire        irw1, pcen1, rw1, rd1, mtr1, asa1, hlt1, ei1, eb1;
    wire [1:0]  asb1, pcs1;
    wire [2:0]  alu1;
    wire [31:0] ret1;

    mips_mc_controller #(.ALUCTRL_W(3), .MAX_WAIT(15), .ENABLE_BNE(1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset0), .op(op0), .funct(funct0), .zero(zero0), .mem(if0),
        .irwrite(irw0), .pcen(pcen0), .regwrite(rw0), .regdst(rd0), .memtoreg(mtr0),
        .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0), .alucontrol(alu0),
        .halted(hlt0), .err_illegal(ei0), .err_bus(eb0), .retired(ret0)
    );

    mips_mc_controller #(.ALUCTRL_W(3), .MAX_WAIT(15), .ENABLE_BNE(0), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset1), .op(op1), .funct(funct1), .zero(zero1), .mem(if1),
        .irwrite(irw1), .pcen(pcen1), .regwrite(rw1), .regdst(rd1), .memtoreg(mtr1),
        .alusrca(asa1), .alusrcb(asb1), .pcsrc(pcs1), .alucontrol(alu1),
        .halted(hlt1), .err_illegal(ei1), .err_bus(eb1), .retired(ret1)
    );

    wire [18:0] ctrl0 = {if0.mem_req, if0.memwrite, if0.iord, irw0, pcen0, rw0, rd0, mtr0,
                         asa0, asb0, pcs0, alu0, hlt0, ei0, eb0};
    wire [18:0] ctrl1 = {if1.mem_req, if1.memwrite, if1.iord, irw1, pcen1, rw1, rd1, mtr1,
                         asa1, asb1, pcs1, alu1, hlt1, ei1, eb1};

    exp_t        sbq[$];
    exp_t        monItem;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRet[2];
    logic        expEi[2];
    logic        expEb[2];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Expected control word {mem_req,memwrite,iord,irwrite,pcen,regwrite,regdst,
    // memtoreg,alusrca,alusrcb,pcsrc,alucontrol,halted,err_illegal,err_bus}.
    function automatic logic [18:0] expCtrl(input bst_t s, input logic rdy, input logic z,
                                            input logic isBne, input logic [5:0] f,
                                            input logic ei, input logic eb);
        logic       mr, mw, io, irw, pe, rw, rd, mt, sa, h;
        logic [1:0] sb, ps;
        logic [2:0] al;
        {mr, mw, io, irw, pe, rw, rd, mt, sa, h} = '0;
        sb = 2'b00;
        ps = 2'b00;
        al = 3'b010;
        case (s)
            B_FETCH:    begin mr = 1; irw = rdy; pe = rdy; sb = 2'b01; end
            B_DECODE:   sb = 2'b11;
            B_MEMADR:   begin sa = 1; sb = 2'b10; end
            B_MEMRD:    begin mr = 1; io = 1; end
            B_MEMWB:    begin rw = 1; mt = 1; end
            B_MEMWR:    begin mr = 1; mw = 1; io = 1; end
            B_RTYPEEX: begin
                sa = 1;
                case (f)
                    6'b100000: al = 3'b010;
                    6'b100010: al = 3'b110;
                    6'b100100: al = 3'b000;
                    6'b100101: al = 3'b001;
                    6'b101010: al = 3'b111;
                    default:   al = 3'bxxx;
                endcase
            end
            B_RTYPEWB:  begin rw = 1; rd = 1; end
            B_BRANCHEX: begin sa = 1; al = 3'b110; ps = 2'b01; pe = isBne ? ~z : z; end
            B_ADDIEX:   begin sa = 1; sb = 2'b10; end
            B_ADDIWB:   rw = 1;
            B_JEX:      begin ps = 2'b10; pe = 1; end
            B_ERROR:    h = 1;
            default:    h = 0;
        endcase
        return {mr, mw, io, irw, pe, rw, rd, mt, sa, sb, ps, al, h, ei, eb};
    endfunction

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input int sel, input string tag, input bst_t s,
                                 input logic [5:0] o, input logic [5:0] f,
                                 input logic z, input logic rdy, input logic rst);
        exp_t e;
        if (sel == 0) begin
            op0 = o; funct0 = f; zero0 = z; if0.mem_ready = rdy; reset0 = rst;
        end else begin
            op1 = o; funct1 = f; zero1 = z; if1.mem_ready = rdy; reset1 = rst;
        end
        if (rst) begin
            expRet[sel] = '0;
            expEi[sel]  = 1'b0;
            expEb[sel]  = 1'b0;
        end
        e.sel  = sel;
        e.tag  = tag;
        e.ctrl = expCtrl(rst ? B_FETCH : s, rst ? 1'b0 : rdy, z, o == T_BNE, f,
                         expEi[sel], expEb[sel]);
        e.ret  = expRet[sel];
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(input int sel, input string name, input logic [5:0] o,
                            input logic [5:0] f, input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++)
            applyStimulus(sel, {name, ":fetchwait"}, B_FETCH, o, f, z, 1'b0, 1'b0);
        applyStimulus(sel, {name, ":fetch"}, B_FETCH, o, f, z, 1'b1, 1'b0);
        applyStimulus(sel, {name, ":decode"}, B_DECODE, o, f, z, dc(), 1'b0);
        case (o)
            T_LW: begin
                applyStimulus(sel, {name, ":memadr"}, B_MEMADR, o, f, z, dc(), 1'b0);
                for (int i = 0; i < mw; i++)
                    applyStimulus(sel, {name, ":memrdwait"}, B_MEMRD, o, f, z, 1'b0, 1'b0);
                applyStimulus(sel, {name, ":memrd"}, B_MEMRD, o, f, z, 1'b1, 1'b0);
                applyStimulus(sel, {name, ":memwb"}, B_MEMWB, o, f, z, dc(), 1'b0);
            end
            T_SW: begin
                applyStimulus(sel, {name, ":memadr"}, B_MEMADR, o, f, z, dc(), 1'b0);
                for (int i = 0; i < mw; i++)
                    applyStimulus(sel, {name, ":memwrwait"}, B_MEMWR, o, f, z, 1'b0, 1'b0);
                applyStimulus(sel, {name, ":memwr"}, B_MEMWR, o, f, z, 1'b1, 1'b0);
            end
            T_RTYPE: begin
                applyStimulus(sel, {name, ":rtypeex"}, B_RTYPEEX, o, f, z, dc(), 1'b0);
                applyStimulus(sel, {name, ":rtypewb"}, B_RTYPEWB, o, f, z, dc(), 1'b0);
            end
            T_BEQ, T_BNE:
                applyStimulus(sel, {name, ":branchex"}, B_BRANCHEX, o, f, z, dc(), 1'b0);
            T_ADDI: begin
                applyStimulus(sel, {name, ":addiex"}, B_ADDIEX, o, f, z, dc(), 1'b0);
                applyStimulus(sel, {name, ":addiwb"}, B_ADDIWB, o, f, z, dc(), 1'b0);
            end
            default:
                applyStimulus(sel, {name, ":jex"}, B_JEX, o, f, z, dc(), 1'b0);
        endcase
        expRet[sel] = expRet[sel] + 32'd1;
    endtask

    // Once halted, random inputs must not disturb outputs or flags.
    task automatic holdError(input int sel, input string name, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(sel, {name, ":error"}, B_ERROR, 6'($urandom_range(0, 63)),
                          6'($urandom_range(0, 63)), dc(), dc(), 1'b0);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            monItem = sbq.pop_front();
            if (monItem.sel == 0) begin
                checkOutput({monItem.tag, "/ctrl"}, 64'(ctrl0), 64'(monItem.ctrl));
                checkOutput({monItem.tag, "/retired"}, 64'(ret0), 64'(monItem.ret));
            end else begin
                checkOutput({monItem.tag, "/ctrl"}, 64'(ctrl1), 64'(monItem.ctrl));
                checkOutput({monItem.tag, "/retired"}, 64'(ret1), 64'(monItem.ret));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset0 = 1'b1; reset1 = 1'b1;
        op0 = '0; funct0 = '0; zero0 = 1'b0; op1 = '0; funct1 = '0; zero1 = 1'b0;
        if0.mem_ready = 1'b0;
        if1.mem_ready = 1'b0;
        expRet = '{default: '0};
        expEi  = '{default: 1'b0};
        expEb  = '{default: 1'b0};
        @(posedge clk);
        #1;

        applyStimulus(0, "reset", B_FETCH, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
        runInstr(0, "lw", T_LW, 6'd0, 1'b0, 0, 0);
        runInstr(0, "sw", T_SW, 6'd0, 1'b0, 0, 3);
        runInstr(0, "add", T_RTYPE, 6'b100000, 1'b0, 0, 0);
        runInstr(0, "sub", T_RTYPE, 6'b100010, 1'b1, 0, 0);
        runInstr(0, "and", T_RTYPE, 6'b100100, 1'b0, 0, 0);
        runInstr(0, "or",  T_RTYPE, 6'b100101, 1'b0, 0, 0);
        runInstr(0, "slt", T_RTYPE, 6'b101010, 1'b0, 0, 0);
        runInstr(0, "addi", T_ADDI, 6'd0, 1'b0, 2, 0);
        runInstr(0, "beq_taken", T_BEQ, 6'd0, 1'b1, 0, 0);
        runInstr(0, "bne_taken", T_BNE, 6'd0, 1'b0, 0, 0);
        runInstr(0, "beq_not", T_BEQ, 6'd0, 1'b0, 0, 0);
        runInstr(0, "bne_not", T_BNE, 6'd0, 1'b1, 0, 0);
        runInstr(0, "j", T_J, 6'd0, 1'b0, 0, 0);
        runInstr(0, "lw_wait", T_LW, 6'd0, 1'b0, 1, 2);

        // Reset lands while a load is stalled in MEMRD with mem_ready now high.
        applyStimulus(0, "rst_mid:fetch", B_FETCH, T_LW, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, "rst_mid:decode", B_DECODE, T_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "rst_mid:memadr", B_MEMADR, T_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "rst_mid:memrd", B_MEMRD, T_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "rst_mid:memrd", B_MEMRD, T_LW, 6'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, "rst_mid:reset", B_FETCH, T_LW, 6'd0, 1'b0, 1'b1, 1'b1);
        runInstr(0, "after_rst", T_ADDI, 6'd0, 1'b0, 0, 0);

        applyStimulus(0, "bad_op:fetch", B_FETCH, 6'b111111, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, "bad_op:decode", B_DECODE, 6'b111111, 6'd0, 1'b0, 1'b0, 1'b0);
        expEi[0] = 1'b1;
        holdError(0, "bad_op", 6);
        applyStimulus(0, "bad_op:reset", B_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);

        applyStimulus(0, "bad_fn:fetch", B_FETCH, T_RTYPE, 6'b000011, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, "bad_fn:decode", B_DECODE, T_RTYPE, 6'b000011, 1'b0, 1'b1, 1'b0);
        expEi[0] = 1'b1;
        holdError(0, "bad_fn", 4);
        applyStimulus(0, "bad_fn:reset", B_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++)
            applyStimulus(0, "timeout:fetchwait", B_FETCH, T_J, 6'd0, 1'b0, 1'b0, 1'b0);
        expEb[0] = 1'b1;
        holdError(0, "timeout", 4);
        applyStimulus(0, "timeout:reset", B_FETCH, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);

        runInstr(0, "edge_ready", T_J, 6'd0, 1'b0, 15, 0);
        runInstr(0, "memwr_edge", T_SW, 6'd0, 1'b0, 0, 15);

        runInstr(1, "nobne_beq", T_BEQ, 6'd0, 1'b1, 0, 0);
        applyStimulus(1, "nobne:fetch", B_FETCH, T_BNE, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, "nobne:decode", B_DECODE, T_BNE, 6'd0, 1'b0, 1'b0, 1'b0);
        expEi[1] = 1'b1;
        holdError(1, "nobne", 3);

        @(negedge clk);
        #1;
        checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
Name: mips_mc_controller

Overview:
- Control unit for the multicycle MIPS core. This is the successor to the single-cycle controller.
- Sequences each instruction through a Moore FSM over a shared instruction/data memory.
- Waits on a memory ready handshake, with a parametrised timeout.
- Flags illegal opcodes and bus errors. Counts retired instructions.
- Sits in the multicycle top beside the multicycle datapath. Takes opcode/funct from the instruction register and zero from the ALU.

Parameters:
ALUCTRL_W, 3, width of alucontrol
MAX_WAIT, 15, max cycles a memory state waits for mem_ready before bus error (1..255)
ENABLE_BNE, 1, 1 = bne legal; 0 = bne opcode is illegal
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
memwrite  out  1  write request (only with mem_req)
iord  out  1  0 = PC address, 1 = ALUOut address
irwrite  out  1  load instruction register
pcen  out  1  PC write enable
regwrite  out  1  register file write
regdst  out  1  1 = rd, 0 = rt
memtoreg  out  1  1 = data register, 0 = ALUOut
alusrca  out  1  0 = PC, 1 = A
alusrcb  out  2  00 B, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
alucontrol  out  ALUCTRL_W  ALU operation
halted  out  1  sticky: FSM in ERROR
err_illegal  out  1  sticky: illegal opcode/funct caused halt
err_bus  out  1  sticky: memory timeout caused halt
retired  out  CNT_W  instructions completed since reset

Behaviour:
- Reset (async):
  - State goes to FETCH. Wait counter, retired and error flags go to 0.
  - While reset is high, irwrite, pcen, regwrite and memwrite are forced to 0.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCHEX, ADDIEX, ADDIWB, JEX, ERROR.
- FETCH:
  - Drives mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite and pcen are asserted only in a cycle with mem_ready=1. That cycle moves to DECODE; otherwise stay.
- DECODE:
  - Drives alusrca=0, alusrcb=11, add.
  - Next state by op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100, and 000101 when ENABLE_BNE -> BRANCHEX; 001000 -> ADDIEX; 000010 -> JEX.
  - Any other op -> ERROR with err_illegal=1.
  - R-type funct not in {100000, 100010, 100100, 100101, 101010} -> ERROR with err_illegal=1.
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD:
  - mem_req=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1, then FETCH.
- MEMWR:
  - mem_req=1, memwrite=1, iord=1, held until mem_ready, then FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct. Encodings: add 010, sub 110, and 000, or 001, slt 111.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0, then FETCH.
- BRANCHEX:
  - alusrca=1, alusrcb=00, sub, pcsrc=01.
  - pcen = zero for beq, ~zero for bne.
  - Then FETCH.
- ADDIEX then ADDIWB: alusrca=1, alusrcb=10, add; then regwrite=1, regdst=0, memtoreg=0; then FETCH.
- JEX: pcsrc=10, pcen=1, then FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR. Increments each cycle in those states without mem_ready.
  - Counter reaching MAX_WAIT with mem_ready still 0 -> ERROR with err_bus=1. Total cycles in the state: MAX_WAIT+1.
  - If mem_ready=1 arrives in the same cycle the limit is hit, mem_ready wins.
- ERROR:
  - Absorbing until reset; halted=1. All enables, mem_req and memwrite are 0.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BRANCHEX, ADDIWB or JEX. Wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0, and alucontrol is add. Outputs are Moore, except irwrite and pcen, which are gated combinationally by mem_ready and zero.
- Latency (mem_ready held 1):
  - lw 5 cycles; sw, R-type and addi 4; beq, bne and j 3.
  - Each memory wait cycle adds 1.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum;
  - opcode and funct localparams;
  - alucontrol encodings;
  - alusrcb/pcsrc encodings.
- Sub-module mips_mc_aludec (funct + aluop -> alucontrol, illegal-funct flag), combinational. The FSM, wait counter and retire counter stay in the top module.

Test Plan:
- Reset asserted mid-MEMRD, then released: state FETCH, retired=0, err flags 0, and no regwrite/memwrite in the reset cycle.
- lw (op=100011) with mem_ready=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite=1 with memtoreg=1 in cycle 5; retired=1.
- sw with mem_ready low 3 cycles in MEMWR: memwrite held 4 cycles and drops after the ready cycle; 7 cycles total.
- beq with zero=1, then bne with zero=0 (ENABLE_BNE=1), then bne with ENABLE_BNE=0: pcen=1 in BRANCHEX for the first two; the third gives ERROR and err_illegal=1.
- op=111111, or R-type funct=000011: ERROR, halted=1, and halted/err flags stay set, with FSM and outputs unaffected, under any later op or mem_ready input.
- FETCH with mem_ready never asserted, MAX_WAIT=15: ERROR with err_bus=1 after 16 cycles in FETCH. Repeat with mem_ready=1 on cycle 16: goes to DECODE, no error.
